mem_wb_stage: RTL and testbench

Parametrised MEM/WB pipeline stage with valid, stall and flush control for the pipelined RISC-V core. It extracts and sign/zero-extends sub-word load data from the aligned data-memory word, and selects the load or ALU result as the writeback value. It flags misaligned loads and counts retired instructions. It sits between the data-memory access and the register-file write port, and also drives the WB-side forwarding inputs.

---
 rtl/riscv_pkg.sv | 14 +
 rtl/load_extend.sv | 52 +++++
 rtl/mem_wb_stage.sv | 99 +++++++++
 tb/tb_mem_wb_stage.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared core constants for the pipelined RISC-V core
// Load funct3 encodings and default datapath widths.
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - sub-word load lane select, extension and misalignment
// Purely combinational; byte lanes assume a 4-byte word.
module load_extend
    import riscv_pkg::*;
#(
    parameter int XLEN_P = XLEN
) (
    input  logic [XLEN_P-1:0] word,
    input  logic [1:0]        off,
    input  logic [2:0]        funct3,
    output logic [XLEN_P-1:0] ext,
    output logic              misaligned
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word[7:0];
        case (off)
            2'd0: byte_v = word[7:0];
            2'd1: byte_v = word[15:8];
            2'd2: byte_v = word[23:16];
            2'd3: byte_v = word[31:24];
            default: byte_v = word[7:0];
        endcase
        half_v = off[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        ext        = word;
        misaligned = 1'b0;
        case (funct3)
            F3_LB:  ext = {{(XLEN_P-8){byte_v[7]}}, byte_v};
            F3_LBU: ext = {{(XLEN_P-8){1'b0}}, byte_v};
            F3_LH: begin
                ext        = {{(XLEN_P-16){half_v[15]}}, half_v};
                misaligned = off[0];
            end
            F3_LHU: begin
                ext        = {{(XLEN_P-16){1'b0}}, half_v};
                misaligned = off[0];
            end
            F3_LW: begin
                ext        = word;
                misaligned = |off;
            end
            default: ext = word;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register with load extraction
// Holds all stage state, the writeback mux and the retired-instruction counter.
module mem_wb_stage
    import riscv_pkg::*;
#(
    parameter int XLEN_P   = XLEN,
    parameter int REG_AW_P = REG_AW,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                stall,
    input  logic                flush,
    input  logic                mem_valid,
    input  logic                mem_regwrite,
    input  logic                mem_memtoreg,
    input  logic [2:0]          mem_funct3,
    input  logic [REG_AW_P-1:0] mem_rd,
    input  logic [XLEN_P-1:0]   mem_alu_result,
    input  logic [XLEN_P-1:0]   data_mem_read_data,
    output logic                wb_valid,
    output logic                wb_regwrite,
    output logic [REG_AW_P-1:0] wb_rd,
    output logic [XLEN_P-1:0]   wb_result,
    output logic                wb_misaligned,
    output logic [CNT_W-1:0]    retired_count
);

    logic [XLEN_P-1:0] load_val;
    logic              load_mis;

    load_extend #(.XLEN_P(XLEN_P)) u_load_extend (
        .word       (data_mem_read_data),
        .off        (mem_alu_result[1:0]),
        .funct3     (mem_funct3),
        .ext        (load_val),
        .misaligned (load_mis)
    );

    logic                valid_q, valid_d;
    logic                regwrite_q, regwrite_d;
    logic [REG_AW_P-1:0] rd_q, rd_d;
    logic [XLEN_P-1:0]   result_q, result_d;
    logic                mis_q, mis_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    // misalignment only matters for loads; ALU ops reuse funct3 bits
    logic mis_eff;
    assign mis_eff = mem_memtoreg & load_mis;

    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        rd_d       = rd_q;
        result_d   = result_q;
        mis_d      = mis_q;
        cnt_d      = cnt_q;
        if (flush) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
            mis_d      = 1'b0;
        end else if (!stall) begin
            valid_d    = mem_valid;
            rd_d       = mem_rd;
            regwrite_d = mem_valid & mem_regwrite & (|mem_rd) & ~mis_eff;
            result_d   = mem_memtoreg ? load_val : mem_alu_result;
            mis_d      = mem_valid & mis_eff;
            if (mem_valid) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            result_q   <= '0;
            mis_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            rd_q       <= rd_d;
            result_q   <= result_d;
            mis_q      <= mis_d;
            cnt_q      <= cnt_d;
        end
    end

    assign wb_valid      = valid_q;
    assign wb_regwrite   = regwrite_q;
    assign wb_rd         = rd_q;
    assign wb_result     = result_q;
    assign wb_misaligned = mis_q;
    assign retired_count = cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed self-checking bench for mem_wb_stage
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_regwrite = 1'b0;
    logic        mem_memtoreg = 1'b0;
    logic [2:0]  mem_funct3 = 3'b000;
    logic [4:0]  mem_rd = '0;
    logic [31:0] mem_alu_result = '0;
    logic [31:0] data_mem_read_data = '0;

    logic        wb_valid, wb_regwrite, wb_misaligned;
    logic [4:0]  wb_rd;
    logic [31:0] wb_result;
    logic [31:0] retired_count;

    logic        s_valid, s_regwrite, s_misaligned;
    logic [4:0]  s_rd;
    logic [31:0] s_result;
    logic [3:0]  s_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(.CNT_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_regwrite(mem_regwrite),
        .mem_memtoreg(mem_memtoreg), .mem_funct3(mem_funct3), .mem_rd(mem_rd),
        .mem_alu_result(mem_alu_result), .data_mem_read_data(data_mem_read_data),
        .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
        .wb_result(wb_result), .wb_misaligned(wb_misaligned),
        .retired_count(retired_count)
    );

    mem_wb_stage #(.CNT_W(4)) dut_small (
        .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_regwrite(mem_regwrite),
        .mem_memtoreg(mem_memtoreg), .mem_funct3(mem_funct3), .mem_rd(mem_rd),
        .mem_alu_result(mem_alu_result), .data_mem_read_data(data_mem_read_data),
        .wb_valid(s_valid), .wb_regwrite(s_regwrite), .wb_rd(s_rd),
        .wb_result(s_result), .wb_misaligned(s_misaligned),
        .retired_count(s_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic mt, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] word);
        mem_valid          = v;
        mem_regwrite       = rw;
        mem_memtoreg       = mt;
        mem_funct3         = f3;
        mem_rd             = rd;
        mem_alu_result     = alu;
        data_mem_read_data = word;
    endtask

    initial begin
        step();
        check("rst_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_regwrite", {31'd0, wb_regwrite}, 32'd0);
        check("rst_result", wb_result, 32'd0);
        check("rst_count", retired_count, 32'd0);
        reset_n = 1'b1;

        // ALU path
        drive(1, 1, 0, 3'b000, 5'd5, 32'h1234_5678, 32'h0);
        step();
        check("alu_result", wb_result, 32'h1234_5678);
        check("alu_regwrite", {31'd0, wb_regwrite}, 32'd1);
        check("alu_rd", {27'd0, wb_rd}, 32'd5);
        check("alu_count", retired_count, 32'd1);

        drive(1, 1, 1, 3'b000, 5'd6, 32'h0000_0103, 32'h80FF_7F01);
        step();
        check("lb_off3", wb_result, 32'hFFFF_FF80);
        check("lb_mis", {31'd0, wb_misaligned}, 32'd0);

        drive(1, 1, 1, 3'b100, 5'd6, 32'h0000_0102, 32'h80FF_7F01);
        step();
        check("lbu_off2", wb_result, 32'h0000_00FF);

        drive(1, 1, 1, 3'b001, 5'd6, 32'h0000_0102, 32'h80FF_7F01);
        step();
        check("lh_off2", wb_result, 32'hFFFF_80FF);

        drive(1, 1, 1, 3'b101, 5'd6, 32'h0000_0100, 32'h80FF_7F01);
        step();
        check("lhu_off0", wb_result, 32'h0000_7F01);
        check("lhu_count", retired_count, 32'd5);

        // misaligned word load
        drive(1, 1, 1, 3'b010, 5'd7, 32'h0000_1002, 32'h80FF_7F01);
        step();
        check("mis_regwrite", {31'd0, wb_regwrite}, 32'd0);
        check("mis_flag", {31'd0, wb_misaligned}, 32'd1);
        check("mis_valid", {31'd0, wb_valid}, 32'd1);
        check("mis_count", retired_count, 32'd6);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 3'b000, 5'(9 + i), 32'hDEAD_0000 + 32'(i), 32'h0);
            step();
            check("stall_result", wb_result, 32'h80FF_7F01);
            check("stall_rd", {27'd0, wb_rd}, 32'd7);
            check("stall_mis", {31'd0, wb_misaligned}, 32'd1);
            check("stall_count", retired_count, 32'd6);
        end

        flush = 1'b1;
        step();
        check("flush_valid", {31'd0, wb_valid}, 32'd0);
        check("flush_regwrite", {31'd0, wb_regwrite}, 32'd0);
        check("flush_mis", {31'd0, wb_misaligned}, 32'd0);
        check("flush_count", retired_count, 32'd6);
        check("flush_rd_hold", {27'd0, wb_rd}, 32'd7);
        stall = 1'b0;
        flush = 1'b0;

        // write to x0 is suppressed but still retires
        drive(1, 1, 0, 3'b000, 5'd0, 32'h0000_00AA, 32'h0);
        step();
        check("x0_regwrite", {31'd0, wb_regwrite}, 32'd0);
        check("x0_valid", {31'd0, wb_valid}, 32'd1);
        check("x0_count", retired_count, 32'd7);

        drive(0, 1, 0, 3'b000, 5'd3, 32'h0000_0055, 32'h0);
        step();
        check("bub_valid", {31'd0, wb_valid}, 32'd0);
        check("bub_regwrite", {31'd0, wb_regwrite}, 32'd0);
        check("bub_result", wb_result, 32'h0000_0055);
        check("bub_count", retired_count, 32'd7);

        // small counter is at 7; 8 more retires reach 15, one more wraps
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 0, 3'b000, 5'd1, 32'(i), 32'h0);
            step();
        end
        check("small_pre_wrap", {28'd0, s_count}, 32'd15);
        step();
        check("small_wrap", {28'd0, s_count}, 32'd0);
        check("big_no_wrap", retired_count, 32'd16);

        // asynchronous reset between edges
        drive(1, 1, 0, 3'b000, 5'd4, 32'h0000_BEEF, 32'h0);
        step();
        check("pre_rst_valid", {31'd0, wb_valid}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, wb_valid}, 32'd0);
        check("arst_regwrite", {31'd0, wb_regwrite}, 32'd0);
        check("arst_rd", {27'd0, wb_rd}, 32'd0);
        check("arst_result", wb_result, 32'd0);
        check("arst_mis", {31'd0, wb_misaligned}, 32'd0);
        check("arst_count", retired_count, 32'd0);
        check("arst_small_count", {28'd0, s_count}, 32'd0);
        step();
        reset_n = 1'b1;
        step();
        check("post_rst_count", retired_count, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
